clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Multi-channel, runtime-programmable clock divider and tick generator for the 12 MHz board clock. Each channel has its own period and high-time. Both can be rewritten through a shared config write port. New values take effect glitch-free at the channel's next period boundary. Each channel outputs a divided clock and a one-cycle tick per period. It replaces the fixed 1 s / 1 ms / 1 us dividers in new designs.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 25, width of period counter, divisor and duty fields
CH_W, 2, width of channel select; must satisfy 2**CH_W >= NUM_CH
DEF_DIV, 12_000_000, reset value of every channel's divisor (1 Hz from 12 MHz)
DEF_DUTY, 6_000_000, reset value of every channel's high-time in clk_in cycles

Ports:
clk_in  input  1  system clock, single clock domain, rising edge
rst  input  1  synchronous, active-high reset
en  input  NUM_CH  per-channel run enable
wr_en  input  1  config write strobe, one write per cycle
wr_ch  input  CH_W  channel addressed by the write
wr_div  input  CNT_W  new divisor (period in clk_in cycles)
wr_duty  input  CNT_W  new high-time in clk_in cycles
clk_out  output  NUM_CH  divided clock per channel, registered
tick  output  NUM_CH  one-cycle pulse at the last cycle of each period, registered
pend  output  NUM_CH  high while a written config is waiting for a boundary

Behaviour:
- Per-channel state: cnt, div_act, duty_act (active), div_sh, duty_sh (shadow), and a pend flag.
- Reset (rst=1 at a clk_in edge) sets:
  - cnt=0
  - div_act=div_sh=DEF_DIV
  - duty_act=duty_sh=DEF_DUTY
  - pend=0, clk_out=0, tick=0
- Reset applies mid-period and discards pending writes.
- Effective divisor D = max(div_act, 1); a divisor of 0 behaves as 1.
- Write: wr_en=1 and wr_ch<NUM_CH captures wr_div and wr_duty into that channel's shadow and sets pend. A write with wr_ch>=NUM_CH is ignored.
  - A second write before the boundary overwrites the shadow; only the last write is used.
- Boundary when en=1: the cycle with cnt==D-1.
  - Next edge: cnt<=0.
  - If pend was set before this edge: div_act<=div_sh, duty_act<=duty_sh, pend<=0.
- A write in the same cycle as a boundary:
  - Lands in the shadow with pend=1.
  - Is applied at the following boundary.
  - If pend was already set, the older shadow is loaded at this boundary and the new write stays pending.
- Non-boundary with en=1: cnt<=cnt+1.
- Outputs, one-cycle latency from cnt:
  - clk_out <= en & (cnt < duty_act)
  - tick <= en & (cnt == D-1)
- Duty limits:
  - duty_act=0 gives constant low.
  - duty_act>=D gives constant high while enabled.
- D=1: cnt stays 0, tick high every cycle, clk_out = (duty_act>=1).
- en=0:
  - cnt held at 0; clk_out and tick driven 0 at the next edge.
  - Any pending shadow is loaded every cycle, so pend clears one cycle after the write.
  - Re-enable starts a fresh period at cnt=0; the first tick arrives D cycles later.
- Channels are fully independent; there are no shared counters.
- Arithmetic: cnt is unsigned CNT_W bits and never wraps, because it resets at D-1 <= 2**CNT_W-2. All compares are unsigned.

Test Plan:
1. Reset defaults: params DEF_DIV=4, DEF_DUTY=2; release rst, en=1 -> clk_out[0] repeats 1,1,0,0 from the first edge after enable; tick[0] pulses once every 4 cycles, coincident with the second 0; pend=0.
2. Write at a boundary: running D=4 and duty=2, write wr_ch=1, wr_div=6, wr_duty=3 in the boundary cycle -> pend[1]=1 for one more full 4-cycle period; then pattern 1,1,1,0,0,0 and tick every 6 cycles; pend[1] clears on the load edge.
3. Back-to-back writes: write div=8 then div=10 (duty=5) mid-period -> only 10 is loaded at the boundary; the period of 8 never appears.
4. Edge values: div=0 and div=1 with duty=1 -> tick and clk_out constant 1; duty=0 -> clk_out constant 0 with tick still per period; duty=9, div=5 -> clk_out constant 1.
5. Enable and reset mid-operation: drop en mid-period -> outputs 0 next cycle and cnt=0; a write while disabled gives pend high for exactly 1 cycle; re-enable gives the first tick after D cycles. Assert rst at cnt=2 -> all outputs 0 and the defaults restored on the same edge.
6. Illegal channel: with NUM_CH=3, a write to wr_ch=3 -> no pend and no behaviour change on any channel.

Source files
------------

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel has a shadowed divisor and high-time that are applied only at a period boundary.
module clk_div_prog #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 25,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned DEF_DIV  = 12_000_000,
    parameter int unsigned DEF_DUTY = 6_000_000
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [CNT_W-1:0]  wr_duty,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] duty_act;
        logic [CNT_W-1:0] div_sh;
        logic [CNT_W-1:0] duty_sh;
        logic             pend_r;
        logic             clk_r;
        logic             tick_r;

        logic [CNT_W-1:0] last_c;
        logic             wr_hit_c;
        logic             bnd_c;
        logic             load_c;

        // A divisor of 0 acts as 1, so the last count is 0 in both cases.
        always_comb begin
            last_c   = (div_act == '0) ? '0 : div_act - CNT_W'(1);
            wr_hit_c = wr_en && (wr_ch == CH_W'(g));
            bnd_c    = en[g] && (cnt == last_c);
            load_c   = pend_r && (bnd_c || !en[g]);
        end

        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt      <= '0;
                div_act  <= CNT_W'(DEF_DIV);
                duty_act <= CNT_W'(DEF_DUTY);
                div_sh   <= CNT_W'(DEF_DIV);
                duty_sh  <= CNT_W'(DEF_DUTY);
                pend_r   <= 1'b0;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else begin
                cnt    <= (!en[g] || bnd_c) ? '0 : cnt + CNT_W'(1);
                clk_r  <= en[g] && (cnt < duty_act);
                tick_r <= bnd_c;
                // Old shadow is loaded before a same-cycle write replaces it.
                if (load_c) begin
                    div_act  <= div_sh;
                    duty_act <= duty_sh;
                end
                if (wr_hit_c) begin
                    div_sh  <= wr_div;
                    duty_sh <= wr_duty;
                end
                pend_r <= wr_hit_c || (pend_r && !load_c);
            end
        end

        assign clk_out[g] = clk_r;
        assign tick[g]    = tick_r;
        assign pend[g]    = pend_r;
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: 3 channels, default divisor 4 with high-time 2.
module tb_clk_div_prog;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 2;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] en = '0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [CNT_W-1:0]  wr_div = '0;
    logic [CNT_W-1:0]  wr_duty = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    int checks = 0;
    int errors = 0;

    clk_div_prog #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEF_DIV(4), .DEF_DUTY(2)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .wr_duty(wr_duty), .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset(input logic [NUM_CH-1:0] e);
        rst = 1'b1; en = '0; wr_en = 1'b0;
        step(); step();
        rst = 1'b0; en = e;
    endtask

    task automatic do_write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d,
                            input logic [CNT_W-1:0] h);
        wr_en = 1'b1; wr_ch = ch; wr_div = d; wr_duty = h;
    endtask

    task automatic test_reset();
        logic [7:0] ec, et;
        ec = 8'b11001100; et = 8'b00010001;
        rst = 1'b1; en = '0; wr_en = 1'b0;
        step(); step();
        checks++;
        if ({clk_out, tick, pend} !== 9'b0) begin
            errors++; $display("FAIL reset_outs got %b exp %b", {clk_out, tick, pend}, 9'b0);
        end
        en = 3'b111;
        step();
        checks++;
        if ({clk_out, tick, pend} !== 9'b0) begin
            errors++; $display("FAIL reset_held_en got %b exp %b", {clk_out, tick, pend}, 9'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (clk_out !== {3{ec[7-i]}} || tick !== {3{et[7-i]}} || pend !== 3'b000) begin
                errors++;
                $display("FAIL reset_default i=%0d got clk %b tick %b pend %b exp clk %b tick %b pend 000",
                         i, clk_out, tick, pend, {3{ec[7-i]}}, {3{et[7-i]}});
            end
        end
    endtask

    task automatic test_boundary_write();
        logic [10:0] ec, et, ep;
        ec = 11'b01100111000; et = 11'b10001000001; ep = 11'b11110000000;
        do_reset(3'b111);
        for (int i = 0; i < 11; i++) step();
        do_write(2'd1, 8'd6, 8'd3);
        for (int i = 0; i < 11; i++) begin
            step();
            wr_en = 1'b0;
            checks++;
            if (clk_out[1] !== ec[10-i] || tick[1] !== et[10-i] || pend[1] !== ep[10-i]) begin
                errors++;
                $display("FAIL bnd_write i=%0d got clk %b tick %b pend %b exp clk %b tick %b pend %b",
                         i, clk_out[1], tick[1], pend[1], ec[10-i], et[10-i], ep[10-i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] ec, et, ep;
        ec = 15'b110011111000001; et = 15'b000100000000010; ep = 15'b011000000000000;
        do_reset(3'b111);
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (clk_out[2] !== ec[14-i] || tick[2] !== et[14-i] || pend[2] !== ep[14-i]) begin
                errors++;
                $display("FAIL b2b i=%0d got clk %b tick %b pend %b exp clk %b tick %b pend %b",
                         i, clk_out[2], tick[2], pend[2], ec[14-i], et[14-i], ep[14-i]);
            end
            if (i == 0) do_write(2'd2, 8'd8, 8'd5);
            else if (i == 1) do_write(2'd2, 8'd10, 8'd5);
            else wr_en = 1'b0;
        end
    endtask

    task automatic test_edge_values();
        logic [2:0] exp_t;
        do_reset(3'b000);
        do_write(2'd0, 8'd0, 8'd1); step();
        do_write(2'd1, 8'd3, 8'd0); step();
        do_write(2'd2, 8'd5, 8'd9); step();
        wr_en = 1'b0; step();
        checks++;
        if ({clk_out, tick, pend} !== 9'b0) begin
            errors++; $display("FAIL edge_loaded got %b exp %b", {clk_out, tick, pend}, 9'b0);
        end
        en = 3'b111;
        for (int i = 0; i < 15; i++) begin
            step();
            exp_t = {(i % 5) == 4, (i % 3) == 2, 1'b1};
            checks++;
            if (clk_out !== 3'b101 || tick !== exp_t) begin
                errors++;
                $display("FAIL edge_run i=%0d got clk %b tick %b exp clk 101 tick %b",
                         i, clk_out, tick, exp_t);
            end
        end
        do_write(2'd0, 8'd1, 8'd1);
        step();
        wr_en = 1'b0;
        checks++;
        if (pend !== 3'b001) begin
            errors++; $display("FAIL div1_pend_set got %b exp 001", pend);
        end
        step();
        checks++;
        if (pend !== 3'b000) begin
            errors++; $display("FAIL div1_pend_clr got %b exp 000", pend);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clk_out[0] !== 1'b1 || tick[0] !== 1'b1) begin
                errors++;
                $display("FAIL div1_run i=%0d got clk %b tick %b exp 1 1", i, clk_out[0], tick[0]);
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [5:0] ec, et;
        logic [3:0] rc, rt;
        ec = 6'b111000; et = 6'b000001; rc = 4'b1100; rt = 4'b0001;
        do_reset(3'b111);
        step(); step();
        en = 3'b110;
        step();
        checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            errors++; $display("FAIL dis_outs got clk %b tick %b exp 0 0", clk_out[0], tick[0]);
        end
        do_write(2'd0, 8'd6, 8'd3);
        step();
        wr_en = 1'b0;
        checks++;
        if (pend[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
            errors++; $display("FAIL dis_pend_set got pend %b clk %b exp 1 0", pend[0], clk_out[0]);
        end
        step();
        checks++;
        if (pend[0] !== 1'b0) begin
            errors++; $display("FAIL dis_pend_clr got %b exp 0", pend[0]);
        end
        en = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (clk_out[0] !== ec[5-i] || tick[0] !== et[5-i]) begin
                errors++;
                $display("FAIL reenable i=%0d got clk %b tick %b exp clk %b tick %b",
                         i, clk_out[0], tick[0], ec[5-i], et[5-i]);
            end
        end
        step();
        do_write(2'd1, 8'd7, 8'd3);
        step();
        wr_en = 1'b0;
        rst = 1'b1;
        checks++;
        if (pend[1] !== 1'b1) begin
            errors++; $display("FAIL pre_rst_pend got %b exp 1", pend[1]);
        end
        step();
        rst = 1'b0;
        checks++;
        if ({clk_out, tick, pend} !== 9'b0) begin
            errors++; $display("FAIL midrst_outs got %b exp %b", {clk_out, tick, pend}, 9'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (clk_out !== {3{rc[3-i]}} || tick !== {3{rt[3-i]}} || pend !== 3'b000) begin
                errors++;
                $display("FAIL post_rst i=%0d got clk %b tick %b pend %b exp clk %b tick %b pend 000",
                         i, clk_out, tick, pend, {3{rc[3-i]}}, {3{rt[3-i]}});
            end
        end
    endtask

    task automatic test_illegal_ch();
        logic [7:0] ec, et;
        ec = 8'b11001100; et = 8'b00010001;
        do_reset(3'b111);
        do_write(2'd3, 8'd6, 8'd3);
        for (int i = 0; i < 8; i++) begin
            step();
            wr_en = 1'b0;
            checks++;
            if (clk_out !== {3{ec[7-i]}} || tick !== {3{et[7-i]}} || pend !== 3'b000) begin
                errors++;
                $display("FAIL illegal_ch i=%0d got clk %b tick %b pend %b exp clk %b tick %b pend 000",
                         i, clk_out, tick, pend, {3{ec[7-i]}}, {3{et[7-i]}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_boundary_write();
        test_back_to_back();
        test_edge_values();
        test_enable_reset();
        test_illegal_ch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
